// File: rtl/ddr5_cmd_sched.sv
// DDR5 single-channel command scheduler: expands each request into ACT + RDA/WRA for pkt_gen.
// Optional issued-command statistics are built when DDR5_CMD_SCHED_STATS_EN is defined.
module ddr5_cmd_sched #(
  parameter int unsigned T_RCD   = 4,
  parameter int unsigned T_RD_AP = 6,
  parameter int unsigned T_WR_AP = 10,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_bg,
  input  logic        req_ba,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic [2:0]  BG,
  output logic        BA,
  output logic [15:0] row,
  output logic [9:0]  col,
  output logic [3:0]  current_state,
  output logic        CS_i,
  output logic        busy,
  output logic        cmd_done,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt
);

  localparam int unsigned RcdEff  = (T_RCD < 2) ? 2 : T_RCD;
  localparam int unsigned RdApEff = (T_RD_AP < 2) ? 2 : T_RD_AP;
  localparam int unsigned WrApEff = (T_WR_AP < 2) ? 2 : T_WR_AP;

  // Loaded one short so the terminal count lands on the last cycle before the next command.
  localparam logic [CNT_W-1:0] RcdLoad  = CNT_W'(RcdEff - 1);
  localparam logic [CNT_W-1:0] RdApLoad = CNT_W'(RdApEff - 1);
  localparam logic [CNT_W-1:0] WrApLoad = CNT_W'(WrApEff - 1);

  localparam logic [3:0] CodeIdle = 4'd0;
  localparam logic [3:0] CodeAct  = 4'd8;
  localparam logic [3:0] CodeWra  = 4'd5;
  localparam logic [3:0] CodeRda  = 4'd12;

  typedef enum logic [2:0] {StIdle, StAct0, StAct1, StRcd, StCas0, StCas1, StRec} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q;
  logic             done_d;
  logic [3:0]       code_d;

  assign req_ready = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StAct0;
          cnt_d   = RcdLoad;
        end
      end
      StAct0: state_d = StAct1;
      StAct1, StRcd: begin
        if (cnt_q == '0) begin
          state_d = StCas0;
          cnt_d   = wr_q ? WrApLoad : RdApLoad;
        end else begin
          state_d = StRcd;
        end
      end
      StCas0: state_d = StCas1;
      StCas1, StRec: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StRec;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    code_d = CodeIdle;
    unique case (state_d)
      StAct0, StAct1: code_d = CodeAct;
      StCas0, StCas1: code_d = wr_q ? CodeWra : CodeRda;
      default:        code_d = CodeIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      BG            <= '0;
      BA            <= 1'b0;
      row           <= '0;
      col           <= '0;
      current_state <= CodeIdle;
      CS_i          <= 1'b0;
      busy          <= 1'b0;
      cmd_done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      current_state <= code_d;
      CS_i          <= (state_d == StAct0) || (state_d == StCas0);
      busy          <= (state_d != StIdle);
      cmd_done      <= done_d;
      if (req_valid && req_ready) begin
        wr_q <= req_wr;
        BG   <= req_bg;
        BA   <= req_ba;
        row  <= req_row;
        col  <= req_col;
      end
    end
  end

`ifdef DDR5_CMD_SCHED_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q;
  logic        cas_entry;

  assign cas_entry = (state_d == StCas0) && (state_q != StCas0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else if (cas_entry) begin
      if (!wr_q && stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
      if (wr_q && stat_wr_q != 16'hFFFF)  stat_wr_q <= stat_wr_q + 16'd1;
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr5_cmd_sched.sv
// Bench for ddr5_cmd_sched: default instance plus a clamped-timing instance (T_RCD=1, T_RD_AP=0).
module tb_ddr5_cmd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_a, valid_b;
  logic        req_wr;
  logic [2:0]  req_bg;
  logic        req_ba;
  logic [15:0] req_row;
  logic [9:0]  req_col;

  logic        rdy_a, rdy_b, csi_a, csi_b, busy_a, busy_b, done_a, done_b, ba_a, ba_b;
  logic [2:0]  bg_a, bg_b;
  logic [15:0] row_a, row_b, srd_a, srd_b, swr_a, swr_b;
  logic [9:0]  col_a, col_b;
  logic [3:0]  st_a, st_b;

  bit          sel;
  logic        o_rdy, o_csi, o_busy, o_done, o_ba;
  logic [2:0]  o_bg;
  logic [15:0] o_row;
  logic [9:0]  o_col;
  logic [3:0]  o_st;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] st;
    logic       csi;
    logic       busy;
    logic       rdy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];

  always #5 clk = ~clk;

  ddr5_cmd_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(rdy_a), .req_wr(req_wr),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .BG(bg_a), .BA(ba_a), .row(row_a), .col(col_a), .current_state(st_a), .CS_i(csi_a),
    .busy(busy_a), .cmd_done(done_a), .stat_rd_cnt(srd_a), .stat_wr_cnt(swr_a)
  );

  ddr5_cmd_sched #(.T_RCD(1), .T_RD_AP(0), .T_WR_AP(10), .CNT_W(8)) dut_clamp (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(rdy_b), .req_wr(req_wr),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .BG(bg_b), .BA(ba_b), .row(row_b), .col(col_b), .current_state(st_b), .CS_i(csi_b),
    .busy(busy_b), .cmd_done(done_b), .stat_rd_cnt(srd_b), .stat_wr_cnt(swr_b)
  );

  assign o_rdy  = sel ? rdy_b  : rdy_a;
  assign o_csi  = sel ? csi_b  : csi_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_ba   = sel ? ba_b   : ba_a;
  assign o_bg   = sel ? bg_b   : bg_a;
  assign o_row  = sel ? row_b  : row_a;
  assign o_col  = sel ? col_b  : col_a;
  assign o_st   = sel ? st_b   : st_a;

  // Expected trace for cycle j after the accept edge, derived from the command timing.
  function automatic exp_t expect_at(int j, int rcd, int ap, logic wr);
    exp_t e;
    e.st   = 4'd0;
    e.csi  = (j == 1) || (j == rcd + 1);
    e.busy = (j <= rcd + ap);
    e.rdy  = (j == rcd + ap + 1);
    e.done = (j == rcd + ap + 1);
    if (j <= 2) e.st = 4'd8;
    else if (j > rcd && j <= rcd + 2) e.st = wr ? 4'd5 : 4'd12;
    return e;
  endfunction

  task automatic do_req(input bit s, input logic wr, input logic [2:0] bg, input logic ba,
                        input logic [15:0] rw, input logic [9:0] cl);
    int   rcd, ap;
    exp_t e;
    sel = s;
    rcd = s ? 2 : 4;
    ap  = s ? 2 : (wr ? 10 : 6);
    @(negedge clk);
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_accept got %b want 1", o_rdy);
    end
    req_wr = wr; req_bg = bg; req_ba = ba; req_row = rw; req_col = cl;
    if (s) valid_b = 1'b1; else valid_a = 1'b1;
    for (int j = 1; j <= rcd + ap + 1; j++) sb.push_back(expect_at(j, rcd, ap, wr));
    for (int j = 1; j <= rcd + ap + 1; j++) begin
      @(negedge clk);
      if (j == 1) begin
        valid_a = 1'b0; valid_b = 1'b0;
        req_bg = 3'($urandom); req_ba = 1'($urandom);
        req_row = 16'($urandom); req_col = 10'($urandom); req_wr = 1'($urandom);
      end
      e = sb.pop_front();
      checks++;
      if (o_st !== e.st || o_csi !== e.csi || o_busy !== e.busy ||
          o_rdy !== e.rdy || o_done !== e.done) begin
        errors++;
        $display("FAIL trace cyc%0d got st=%0d cs=%b busy=%b rdy=%b done=%b want st=%0d cs=%b busy=%b rdy=%b done=%b",
                 j, o_st, o_csi, o_busy, o_rdy, o_done, e.st, e.csi, e.busy, e.rdy, e.done);
      end
      checks++;
      if (o_bg !== bg || o_ba !== ba || o_row !== rw || o_col !== cl) begin
        errors++;
        $display("FAIL addr cyc%0d got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h",
                 j, o_bg, o_ba, o_row, o_col, bg, ba, rw, cl);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rdy_a !== 1'b1 || st_a !== 4'd0 || csi_a !== 1'b0 || busy_a !== 1'b0 ||
        done_a !== 1'b0 || bg_a !== 3'd0 || ba_a !== 1'b0 || row_a !== 16'd0 ||
        col_a !== 10'd0 || srd_a !== 16'd0 || swr_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b st=%0d cs=%b busy=%b done=%b addr=%0h/%0h/%0h/%0h",
               rdy_a, st_a, csi_a, busy_a, done_a, bg_a, ba_a, row_a, col_a);
    end
  endtask

  task automatic test_read();
    do_req(1'b0, 1'b0, 3'd3, 1'b1, 16'hABCD, 10'h155);
  endtask

  task automatic test_write();
    do_req(1'b0, 1'b1, 3'd5, 1'b0, 16'h1234, 10'h2AA);
  endtask

  task automatic test_clamp();
    do_req(1'b1, 1'b0, 3'd6, 1'b1, 16'h0F0F, 10'h0C3);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0, dones = 0, first = -1, got;
    sel = 1'b0;
    acc_q.push_back(0); acc_q.push_back(11); acc_q.push_back(22);
    req_wr = 1'b0; req_bg = 3'd1; req_ba = 1'b0; req_row = 16'h0042; req_col = 10'h011;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) valid_a = 1'b1;
      if (done_a === 1'b1) dones++;
      if (valid_a && rdy_a === 1'b1) begin
        if (first < 0) first = c;
        n++;
        checks++;
        got = c - first;
        if (acc_q.size() == 0 || got != acc_q[0]) begin
          errors++;
          $display("FAIL b2b_accept got %0d want %0d", got, (acc_q.size() != 0) ? acc_q[0] : -1);
        end
        if (acc_q.size() != 0) void'(acc_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (n == 3) valid_a = 1'b0;
    end
    checks++;
    if (n != 3 || dones != 3) begin
      errors++;
      $display("FAIL b2b_counts got accepts=%0d dones=%0d want 3 and 3", n, dones);
    end
    acc_q.delete();
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    @(negedge clk);
    req_wr = 1'b0; req_bg = 3'd2; req_ba = 1'b1; req_row = 16'h5555; req_col = 10'h3FF;
    valid_a = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      valid_a = 1'b0;
    end
    checks++;
    if (st_a !== 4'd12) begin
      errors++;
      $display("FAIL mid_cas_before_reset got %0d want 12", st_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (st_a !== 4'd0 || busy_a !== 1'b0 || rdy_a !== 1'b1 || csi_a !== 1'b0 || row_a !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got st=%0d busy=%b rdy=%b cs=%b row=%0h want 0/0/1/0/0",
               st_a, busy_a, rdy_a, csi_a, row_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (st_a !== 4'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL no_replay got st=%0d busy=%b want 0/0", st_a, busy_a);
    end
    do_req(1'b0, 1'b0, 3'd7, 1'b0, 16'hBEEF, 10'h001);
  endtask

  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 1'b0, 3'd1, 1'b0, 16'h0001, 10'h001);
    do_req(1'b0, 1'b1, 3'd2, 1'b1, 16'h0002, 10'h002);
    do_req(1'b0, 1'b0, 3'd3, 1'b0, 16'h0003, 10'h003);
`ifdef DDR5_CMD_SCHED_STATS_EN
    checks++;
    if (srd_a !== 16'd2 || swr_a !== 16'd1) begin
      errors++;
      $display("FAIL stats_counts got rd=%0d wr=%0d want 2 and 1", srd_a, swr_a);
    end
    force dut.stat_rd_q = 16'hFFFF;
    @(negedge clk);
    release dut.stat_rd_q;
    do_req(1'b0, 1'b0, 3'd4, 1'b0, 16'h0004, 10'h004);
    checks++;
    if (srd_a !== 16'hFFFF || swr_a !== 16'd1) begin
      errors++;
      $display("FAIL stats_saturate got rd=%0h wr=%0d want ffff and 1", srd_a, swr_a);
    end
`else
    checks++;
    if (srd_a !== 16'd0 || swr_a !== 16'd0 || srd_b !== 16'd0 || swr_b !== 16'd0) begin
      errors++;
      $display("FAIL stats_tied_off got rd=%0d wr=%0d want 0 and 0", srd_a, swr_a);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; sel = 1'b0;
    req_wr = 1'b0; req_bg = '0; req_ba = 1'b0; req_row = '0; req_col = '0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_read();
    test_write();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
